// File: rtl/ps2_frame_rx_if.sv
// rtl/ps2_frame_rx_if.sv - key event bus from the PS/2 frame receiver
// Purpose: carries decoded scan codes and frame status out of ps2_frame_rx.
// Signals:
//    keycode[7:0]  last delivered scan code, held between deliveries
//    key_valid     one-cycle pulse, keycode/key_release/extended valid
//    key_release   delivered code was preceded by 0xF0
//    extended      delivered code was preceded by 0xE0
//    frame_err     one-cycle pulse on parity, stop-bit or timeout error
//    busy          receiver is inside a frame
// Modports: master drives the bus (receiver), slave observes it.
interface ps2_frame_rx_if;
   logic [7:0] keycode;
   logic       key_valid;
   logic       key_release;
   logic       extended;
   logic       frame_err;
   logic       busy;

   modport master (
      output keycode, key_valid, key_release, extended, frame_err, busy
   );

   modport slave (
      input keycode, key_valid, key_release, extended, frame_err, busy
   );
endinterface

// File: rtl/ps2_frame_rx.sv
// rtl/ps2_frame_rx.sv - PS/2 keyboard frame receiver with prefix decoding
// Purpose: synchronizes and deglitches the PS/2 clock, receives 11-bit
// frames (start, 8 data LSB first, odd parity, stop), folds 0xE0/0xF0
// prefixes into flags and delivers scan codes on key_if.
// Ports:
//    clk      system clock, rising edge
//    rst_n    asynchronous active-low reset
//    kbdclk   raw PS/2 clock pin (asynchronous)
//    kbddat   raw PS/2 data pin (asynchronous)
//    key_if   key event bus, master side
module ps2_frame_rx #(
   parameter int FILTER_LEN     = 4,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           kbdclk,
   input  logic           kbddat,
   ps2_frame_rx_if.master key_if
);

   localparam int FCW = $clog2(FILTER_LEN + 1);
   localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2,
      STOP   = 2'd3
   } state_t;

   // Synchronizers and filter reset to 1 so the bus looks idle.
   logic           clk_s1_q, clk_s2_q;
   logic           dat_s1_q, dat_s2_q;
   logic [FCW-1:0] filt_cnt_q, filt_cnt_d;
   logic           filt_q, filt_d;
   logic           filt_prev_q;
   logic           fall;

   state_t         state_q;
   logic [2:0]     bit_cnt_q;
   logic [7:0]     shift_q;
   logic           par_err_q;
   logic           rel_flag_q;
   logic           ext_flag_q;
   logic [TCW-1:0] tmo_q;
   logic           tmo_hit;

   logic [7:0]     keycode_q;
   logic           key_valid_q;
   logic           key_release_q;
   logic           extended_q;
   logic           frame_err_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clk_s1_q    <= 1'b1;
         clk_s2_q    <= 1'b1;
         dat_s1_q    <= 1'b1;
         dat_s2_q    <= 1'b1;
         filt_cnt_q  <= '0;
         filt_q      <= 1'b1;
         filt_prev_q <= 1'b1;
      end else begin
         clk_s1_q    <= kbdclk;
         clk_s2_q    <= clk_s1_q;
         dat_s1_q    <= kbddat;
         dat_s2_q    <= dat_s1_q;
         filt_cnt_q  <= filt_cnt_d;
         filt_q      <= filt_d;
         filt_prev_q <= filt_q;
      end
   end

   // The run counter tracks how many consecutive samples disagree with the
   // filtered level; the FILTER_LEN-th disagreeing sample flips it.
   always_comb begin
      filt_cnt_d = '0;
      filt_d     = filt_q;
      if (clk_s2_q != filt_q) begin
         if (filt_cnt_q == FCW'(FILTER_LEN - 1)) begin
            filt_d = clk_s2_q;
         end else begin
            filt_cnt_d = filt_cnt_q + 1'b1;
         end
      end
   end

   assign fall = filt_prev_q & ~filt_q;

   // Timeout wins over a coincident falling edge, so a start bit seen in
   // the abort cycle is dropped.
   assign tmo_hit = (state_q != IDLE) && (tmo_q == TCW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         bit_cnt_q     <= '0;
         shift_q       <= '0;
         par_err_q     <= 1'b0;
         rel_flag_q    <= 1'b0;
         ext_flag_q    <= 1'b0;
         tmo_q         <= '0;
         keycode_q     <= '0;
         key_valid_q   <= 1'b0;
         key_release_q <= 1'b0;
         extended_q    <= 1'b0;
         frame_err_q   <= 1'b0;
      end else begin
         key_valid_q <= 1'b0;
         frame_err_q <= 1'b0;

         if (state_q == IDLE || fall) begin
            tmo_q <= '0;
         end else begin
            tmo_q <= tmo_q + 1'b1;
         end

         if (tmo_hit) begin
            state_q     <= IDLE;
            frame_err_q <= 1'b1;
            rel_flag_q  <= 1'b0;
            ext_flag_q  <= 1'b0;
            tmo_q       <= '0;
         end else if (fall) begin
            case (state_q)
               IDLE: begin
                  if (!dat_s2_q) begin
                     state_q   <= DATA;
                     bit_cnt_q <= '0;
                     par_err_q <= 1'b0;
                  end
               end
               DATA: begin
                  shift_q   <= {dat_s2_q, shift_q[7:1]};
                  bit_cnt_q <= bit_cnt_q + 1'b1;
                  if (bit_cnt_q == 3'd7) begin
                     state_q <= PARITY;
                  end
               end
               PARITY: begin
                  // Odd parity: even total weight is an error.
                  par_err_q <= ~(^{shift_q, dat_s2_q});
                  state_q   <= STOP;
               end
               STOP: begin
                  state_q <= IDLE;
                  if (!dat_s2_q || par_err_q) begin
                     frame_err_q <= 1'b1;
                     rel_flag_q  <= 1'b0;
                     ext_flag_q  <= 1'b0;
                  end else if (shift_q == 8'hF0) begin
                     rel_flag_q <= 1'b1;
                  end else if (shift_q == 8'hE0) begin
                     ext_flag_q <= 1'b1;
                  end else begin
                     keycode_q     <= shift_q;
                     key_release_q <= rel_flag_q;
                     extended_q    <= ext_flag_q;
                     key_valid_q   <= 1'b1;
                     rel_flag_q    <= 1'b0;
                     ext_flag_q    <= 1'b0;
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign key_if.keycode     = keycode_q;
   assign key_if.key_valid   = key_valid_q;
   assign key_if.key_release = key_release_q;
   assign key_if.extended    = extended_q;
   assign key_if.frame_err   = frame_err_q;
   assign key_if.busy        = (state_q != IDLE);

endmodule

// File: tb/tb_ps2_frame_rx.sv
// tb/tb_ps2_frame_rx.sv - scoreboard bench for ps2_frame_rx
module tb_ps2_frame_rx;

   localparam int FL   = 4;
   localparam int TMO  = 400;
   localparam int HALF = 20;

   typedef struct {
      bit         is_err;
      logic [7:0] code;
      bit         rel;
      bit         ext;
      int         cyc;
      bit         chk_lat;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic kbdclk = 1'b1;
   logic kbddat = 1'b1;
   int   cyc = 0;
   int   n_vec = 0;
   int   n_err = 0;
   logic [7:0] last_code = 8'h00;
   exp_t sb[$];
   exp_t mon_e;

   ps2_frame_rx_if key_if();

   ps2_frame_rx #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TMO)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .kbdclk (kbdclk),
      .kbddat (kbddat),
      .key_if (key_if)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(string name, int act, int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endfunction

   task automatic tick(int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   // One PS/2 bit: data set while clock high, then a low phase.
   // Glitches of FL-1 cycles are injected in both phases when requested.
   task automatic send_bit(bit b, bit glitch);
      kbddat = b;
      if (glitch) begin
         tick(5);
         kbdclk = 1'b0;
         tick(FL - 1);
         kbdclk = 1'b1;
         tick(HALF - 5 - (FL - 1));
      end else begin
         tick(HALF);
      end
      kbdclk = 1'b0;
      if (glitch) begin
         tick(5);
         kbdclk = 1'b1;
         tick(FL - 1);
         kbdclk = 1'b0;
         tick(HALF - 5 - (FL - 1));
      end else begin
         tick(HALF);
      end
      kbdclk = 1'b1;
   endtask

   // kind: 0 no output expected, 1 key_valid, 2 frame_err
   task automatic send_frame(logic [7:0] d, bit par_ok, bit stop, bit glitch,
                             int kind, bit rel, bit ext);
      bit   bits [11];
      exp_t e;
      bits[0] = 1'b0;
      for (int i = 0; i < 8; i++) bits[i+1] = d[i];
      bits[9]  = par_ok ? ~(^d) : (^d);
      bits[10] = stop;
      for (int i = 0; i < 10; i++) send_bit(bits[i], glitch);
      kbddat = bits[10];
      tick(HALF);
      kbdclk = 1'b0;
      if (kind != 0) begin
         e.is_err  = (kind == 2);
         e.code    = (kind == 1) ? d : last_code;
         e.rel     = rel;
         e.ext     = ext;
         e.cyc     = cyc + FL + 3;
         e.chk_lat = 1'b1;
         sb.push_back(e);
         if (kind == 1) last_code = d;
      end
      tick(HALF);
      kbdclk = 1'b1;
      kbddat = 1'b1;
      tick(50);
   endtask

   always @(negedge clk) begin
      if (rst_n && (key_if.key_valid || key_if.frame_err)) begin
         if (key_if.key_valid && key_if.frame_err) begin
            chk("valid_and_err_together", 1, 0);
         end else if (sb.size() == 0) begin
            chk("unexpected_pulse", 1, 0);
         end else begin
            mon_e = sb.pop_front();
            chk("pulse_kind_err", int'(key_if.frame_err), int'(mon_e.is_err));
            chk("keycode", int'(key_if.keycode), int'(mon_e.code));
            if (!mon_e.is_err) begin
               chk("key_release", int'(key_if.key_release), int'(mon_e.rel));
               chk("extended", int'(key_if.extended), int'(mon_e.ext));
            end
            if (mon_e.chk_lat) chk("latency_cycle", cyc, mon_e.cyc);
         end
      end
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      exp_t e;
      tick(3);
      chk("rst_keycode", int'(key_if.keycode), 0);
      chk("rst_key_valid", int'(key_if.key_valid), 0);
      chk("rst_key_release", int'(key_if.key_release), 0);
      chk("rst_extended", int'(key_if.extended), 0);
      chk("rst_frame_err", int'(key_if.frame_err), 0);
      chk("rst_busy", int'(key_if.busy), 0);
      rst_n = 1'b1;
      tick(10);

      send_frame(8'h1C, 1, 1, 0, 1, 0, 0);
      send_frame(8'hF0, 1, 1, 0, 0, 0, 0);
      send_frame(8'h1C, 1, 1, 0, 1, 1, 0);
      send_frame(8'h32, 1, 1, 0, 1, 0, 0);
      send_frame(8'hE0, 1, 1, 0, 0, 0, 0);
      send_frame(8'hF0, 1, 1, 0, 0, 0, 0);
      send_frame(8'h75, 1, 1, 0, 1, 1, 1);
      send_frame(8'hAA, 1, 1, 0, 1, 0, 0);
      send_frame(8'h1C, 0, 1, 0, 2, 0, 0);
      send_frame(8'hF0, 1, 1, 0, 0, 0, 0);
      send_frame(8'h12, 1, 0, 0, 2, 0, 0);
      send_frame(8'h1C, 1, 1, 0, 1, 0, 0);
      send_frame(8'hFA, 1, 1, 0, 1, 0, 0);

      // Truncated frame: start plus 3 data bits of 0x4D, then clock idles high.
      send_bit(1'b0, 0);
      send_bit(1'b1, 0);
      send_bit(1'b0, 0);
      send_bit(1'b1, 0);
      chk("busy_mid_frame", int'(key_if.busy), 1);
      e.is_err = 1; e.code = last_code; e.rel = 0; e.ext = 0;
      e.cyc = 0; e.chk_lat = 0;
      sb.push_back(e);
      tick(TMO + 50);
      chk("busy_after_timeout", int'(key_if.busy), 0);
      send_frame(8'h4D, 1, 1, 0, 1, 0, 0);

      send_frame(8'h2D, 1, 1, 1, 1, 0, 0);

      // Reset in the middle of a frame.
      send_bit(1'b0, 0);
      send_bit(1'b1, 0);
      send_bit(1'b1, 0);
      rst_n = 1'b0;
      tick(3);
      chk("midrst_busy", int'(key_if.busy), 0);
      chk("midrst_keycode", int'(key_if.keycode), 0);
      chk("midrst_frame_err", int'(key_if.frame_err), 0);
      chk("midrst_key_valid", int'(key_if.key_valid), 0);
      rst_n = 1'b1;
      last_code = 8'h00;
      tick(30);
      send_frame(8'h5A, 1, 1, 0, 1, 0, 0);

      for (int i = 0; i < 200 && sb.size() != 0; i++) tick(1);
      chk("scoreboard_drained", sb.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/ps2_frame_rx.md
PS2_FRAME_RX -- requirements
Module: ps2_frame_rx

Interface
REQ-001 Parameter FILTER_LEN, default 4: consecutive identical synchronized kbdclk samples required before the filtered clock changes.
REQ-002 Parameter TIMEOUT_CYCLES, default 100000: clk cycles allowed between falling edges inside a frame before the frame is aborted.
REQ-003 Port clk  input  1  system clock; all state changes on its rising edge.
REQ-004 Port rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-005 Port kbdclk  input  1  raw PS/2 clock pin, asynchronous to clk.
REQ-006 Port kbddat  input  1  raw PS/2 data pin, asynchronous to clk.
REQ-007 Port keycode  output  8  last delivered scan code; holds its value between deliveries.
REQ-008 Port key_valid  output  1  one-cycle pulse; keycode, key_release and extended are valid in this cycle.
REQ-009 Port key_release  output  1  high when the delivered code was preceded by 0xF0.
REQ-010 Port extended  output  1  high when the delivered code was preceded by 0xE0.
REQ-011 Port frame_err  output  1  one-cycle pulse on a parity, stop-bit or timeout error.
REQ-012 Port busy  output  1  high while the FSM is not in IDLE.

Function
REQ-013 kbdclk and kbddat SHALL each pass through a two-flop synchronizer.
REQ-014 Filtered clock SHALL change only after FILTER_LEN consecutive equal synchronized samples; shorter pulses are ignored.
REQ-015 A falling edge SHALL be the single cycle in which filtered clock is 0 and its previous value was 1; synchronized kbddat is sampled in that cycle.
REQ-016 FSM states SHALL be IDLE, DATA, PARITY, STOP; all transitions occur only on falling-edge cycles, except timeout.
REQ-017 IDLE: sampled 0 (start bit) -> DATA, bit counter = 0; sampled 1 -> stay in IDLE, no error.
REQ-018 DATA: shift in 8 bits LSB first; after the 8th bit -> PARITY.
REQ-019 PARITY: error if the 8 data bits plus the parity bit have even weight (odd parity required); -> STOP either way.
REQ-020 STOP: sampled 0 or an earlier parity error -> frame_err pulse; otherwise deliver the byte; -> IDLE in both cases.
REQ-021 Delivery of 0xF0 SHALL set the release flag with no key_valid; delivery of 0xE0 SHALL set the extended flag with no key_valid.
REQ-022 Delivery of any other byte, including 0xAA and 0xFA, SHALL load keycode, drive key_release and extended from the flags, pulse key_valid, then clear both flags.
REQ-023 key_valid or frame_err SHALL assert in the cycle after the stop-bit falling-edge cycle, for exactly one cycle.
REQ-024 Pin-to-edge latency SHALL be 2 + FILTER_LEN clk cycles.
REQ-025 The timeout counter SHALL clear on every falling edge and count while busy; reaching TIMEOUT_CYCLES -> frame_err pulse, flags cleared, IDLE.
REQ-026 Any frame_err SHALL discard the partial byte, clear both prefix flags and leave keycode unchanged.
REQ-027 A 0xF0 or 0xE0 prefix followed by an error SHALL NOT carry over to the next code.
REQ-028 A start bit detected in the same cycle as a timeout abort SHALL be ignored.
REQ-029 key_valid and frame_err SHALL never be high in the same cycle.

Reset
REQ-030 While rst_n = 0: FSM in IDLE, keycode = 0x00, key_valid = key_release = extended = frame_err = busy = 0, flags, counters and shift register cleared, synchronizers and filter at 1 (bus idle).
REQ-031 Reset asserted mid-frame SHALL abort the frame with no frame_err.
REQ-032 After rst_n rises, the first valid start bit SHALL be received correctly.

Verification
REQ-033 Frame 0x1C, parity 0, stop 1 -> one key_valid pulse, keycode = 0x1C, key_release = 0, extended = 0, frame_err = 0.
REQ-034 Frames 0xF0, 0x1C -> a single key_valid pulse, after the second frame only, with keycode = 0x1C and key_release = 1; next frame 0x32 -> key_release = 0.
REQ-035 Frames 0xE0, 0xF0, 0x75 -> a single key_valid pulse with keycode = 0x75, extended = 1, key_release = 1.
REQ-036 Frame 0x1C with parity 1 -> frame_err pulse, no key_valid, keycode keeps its previous value; frames 0xF0 then a bad-stop frame then 0x1C -> key_release = 0.
REQ-037 Start bit plus 3 data bits, then clock held high for TIMEOUT_CYCLES -> frame_err pulse, busy = 0; next clean frame 0x4D is received.
REQ-038 Glitches of FILTER_LEN-1 cycles on kbdclk during frame 0x2D -> keycode = 0x2D; rst_n pulsed low mid-frame -> no outputs asserted, next frame received.
